// File: rtl/image_write_stream.sv
// Sink of the dual-pixel image stream: buffers pixel pairs and emits a top-down 24-bit BMP byte stream.
// Optional build macro GRAYSCALE_OUT_EN replaces each pixel by its luma at the FIFO input.
module image_write_stream #(
  parameter int WIDTH      = 768,
  parameter int HEIGHT     = 512,
  parameter int FIFO_DEPTH = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       vsync,
  input  logic       hsync,
  input  logic [7:0] red_0,
  input  logic [7:0] green_0,
  input  logic [7:0] blue_0,
  input  logic [7:0] red_1,
  input  logic [7:0] green_1,
  input  logic [7:0] blue_1,
  output logic       in_ready,
  output logic [7:0] out_data,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       out_last,
  output logic       frame_done,
  output logic       overflow
);

  localparam int PADB          = (4 - (WIDTH * 3) % 4) % 4;
  localparam int RB            = WIDTH * 3 + PADB;
  localparam int PAIRS_PER_ROW = WIDTH / 2;
  localparam int TOTAL_PAIRS   = PAIRS_PER_ROW * HEIGHT;
  localparam int CW            = $clog2(PAIRS_PER_ROW + 1);
  localparam int RW            = $clog2(HEIGHT + 1);
  localparam int AW            = $clog2(TOTAL_PAIRS + 1);
  localparam int PW            = $clog2(FIFO_DEPTH);

  localparam logic [31:0] FSZ        = 32'(54 + RB * HEIGHT);
  localparam logic [31:0] IMG_SIZE   = 32'(RB * HEIGHT);
  localparam logic [31:0] NEG_HEIGHT = 32'(-HEIGHT);
  localparam logic [PW:0] FIFO_FULL  = FIFO_DEPTH[PW:0];

  localparam logic [CW-1:0] LAST_COL  = CW'(PAIRS_PER_ROW - 1);
  localparam logic [RW-1:0] LAST_ROW  = RW'(HEIGHT - 1);
  localparam logic [AW-1:0] ALL_PAIRS = AW'(TOTAL_PAIRS);
  localparam logic [1:0]    LAST_PAD  = 2'(PADB - 1);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_HEADER = 3'd1;
  localparam logic [2:0] S_PIXEL  = 3'd2;
  localparam logic [2:0] S_PAD    = 3'd3;
  localparam logic [2:0] S_DONE   = 3'd4;

  logic [2:0]    state;
  logic          vsync_d;
  logic [5:0]    hdr_idx;
  logic [2:0]    byte_sel;
  logic [CW-1:0] col_cnt;
  logic [RW-1:0] row_cnt;
  logic [1:0]    pad_cnt;
  logic [AW-1:0] acc_cnt;

  logic [47:0]   mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [PW:0]   fcount;

  logic        fifo_full;
  logic        fifo_empty;
  logic        excess;
  logic        push;
  logic        pop;
  logic        xfer;
  logic        overflow_set;
  logic        last_col;
  logic        last_row;
  logic [47:0] push_data;
  logic [47:0] head;
  logic [7:0]  pix_byte;
  logic [5:0]  hdr_off;
  logic [31:0] hdr_w;
  logic [7:0]  hdr_byte;

  // BMP header after the "BM" magic: thirteen little-endian 32-bit words.
  function automatic logic [31:0] hdr_word(input logic [3:0] w);
    case (w)
      4'd0:        return FSZ;
      4'd2:        return 32'd54;
      4'd3:        return 32'd40;
      4'd4:        return 32'(WIDTH);
      4'd5:        return NEG_HEIGHT;
      4'd6:        return 32'h0018_0001;
      4'd8:        return IMG_SIZE;
      4'd9, 4'd10: return 32'd2835;
      default:     return 32'd0;
    endcase
  endfunction

`ifdef GRAYSCALE_OUT_EN
  function automatic logic [7:0] luma(input logic [7:0] r, input logic [7:0] g,
                                      input logic [7:0] b);
    logic [9:0] sum;
    sum = {2'b00, r} + {1'b0, g, 1'b0} + {2'b00, b};
    return sum[9:2];
  endfunction

  logic [7:0] y0;
  logic [7:0] y1;
  assign y0        = luma(red_0, green_0, blue_0);
  assign y1        = luma(red_1, green_1, blue_1);
  assign push_data = {y1, y1, y1, y0, y0, y0};
`else
  assign push_data = {red_1, green_1, blue_1, red_0, green_0, blue_0};
`endif

  assign fifo_full    = (fcount == FIFO_FULL);
  assign fifo_empty   = (fcount == '0);
  assign excess       = (acc_cnt == ALL_PAIRS);
  assign in_ready     = (state != S_IDLE) && !fifo_full;
  assign push         = hsync && in_ready && (state != S_DONE) && !excess;
  assign overflow_set = hsync && (!in_ready || (state == S_DONE) || excess);
  assign xfer         = out_valid && out_ready;
  assign pop          = (state == S_PIXEL) && xfer && (byte_sel == 3'd5);
  assign last_col     = (col_cnt == LAST_COL);
  assign last_row     = (row_cnt == LAST_ROW);
  assign frame_done   = (state == S_DONE);

  assign head     = mem[rd_ptr];
  assign pix_byte = head[{byte_sel, 3'b000} +: 8];
  assign hdr_off  = hdr_idx - 6'd2;
  assign hdr_w    = hdr_word(hdr_off[5:2]);

  always_comb begin
    // NOTE: every combinational output gets a default first so no path infers a latch.
    hdr_byte  = hdr_w[{hdr_off[1:0], 3'b000} +: 8];
    out_valid = 1'b0;
    out_data  = 8'h00;
    out_last  = 1'b0;
    if (hdr_idx == 6'd0)      hdr_byte = 8'h42;
    else if (hdr_idx == 6'd1) hdr_byte = 8'h4D;
    case (state)
      S_HEADER: begin
        out_valid = 1'b1;
        out_data  = hdr_byte;
      end
      S_PIXEL: begin
        out_valid = !fifo_empty;
        out_data  = fifo_empty ? 8'h00 : pix_byte;
        out_last  = !fifo_empty && (PADB == 0) && (byte_sel == 3'd5) && last_col && last_row;
      end
      S_PAD: begin
        out_valid = 1'b1;
        out_last  = (pad_cnt == LAST_PAD) && last_row;
      end
      default: ;
    endcase
  end

  // NOTE: the pair storage has no reset; only pointers and count define FIFO contents.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_data;
  end

  // NOTE: all sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      vsync_d  <= 1'b0;
      overflow <= 1'b0;
      hdr_idx  <= '0;
      byte_sel <= '0;
      col_cnt  <= '0;
      row_cnt  <= '0;
      pad_cnt  <= '0;
      acc_cnt  <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fcount   <= '0;
    end else begin
      vsync_d <= vsync;
      if (overflow_set) overflow <= 1'b1;
      if (push) acc_cnt <= acc_cnt + 1'b1;

      // Leaving DONE for IDLE discards anything still buffered.
      if (state == S_DONE) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        fcount <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + 1'b1;
        if (pop)  rd_ptr <= rd_ptr + 1'b1;
        case ({push, pop})
          2'b10:   fcount <= fcount + 1'b1;
          2'b01:   fcount <= fcount - 1'b1;
          default: ;
        endcase
      end

      case (state)
        S_IDLE: begin
          if (vsync && !vsync_d) begin
            state    <= S_HEADER;
            hdr_idx  <= '0;
            byte_sel <= '0;
            col_cnt  <= '0;
            row_cnt  <= '0;
            pad_cnt  <= '0;
            acc_cnt  <= '0;
          end
        end
        S_HEADER: begin
          if (xfer) begin
            if (hdr_idx == 6'd53) begin
              hdr_idx <= '0;
              state   <= S_PIXEL;
            end else begin
              hdr_idx <= hdr_idx + 1'b1;
            end
          end
        end
        S_PIXEL: begin
          if (xfer) begin
            if (byte_sel == 3'd5) begin
              byte_sel <= '0;
              if (last_col) begin
                col_cnt <= '0;
                if (PADB != 0) begin
                  pad_cnt <= '0;
                  state   <= S_PAD;
                end else if (last_row) begin
                  row_cnt <= '0;
                  state   <= S_DONE;
                end else begin
                  row_cnt <= row_cnt + 1'b1;
                end
              end else begin
                col_cnt <= col_cnt + 1'b1;
              end
            end else begin
              byte_sel <= byte_sel + 1'b1;
            end
          end
        end
        S_PAD: begin
          if (xfer) begin
            if (pad_cnt == LAST_PAD) begin
              pad_cnt <= '0;
              if (last_row) begin
                row_cnt <= '0;
                state   <= S_DONE;
              end else begin
                row_cnt <= row_cnt + 1'b1;
                state   <= S_PIXEL;
              end
            end else begin
              pad_cnt <= pad_cnt + 1'b1;
            end
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
